// File: rtl/regfile_mp.sv
// Multi-port register file: DEPTH x WIDTH reset-able flops, NREAD read ports,
// one write port, optional hardwired-zero entry, bypass and registered read.
module regfile_mp_rport #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int FWD      = 1
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wa,
    input  logic [WIDTH-1:0]            wd,
    input  logic [ADDR_W-1:0]           ra,
    output logic [WIDTH-1:0]            raw
);
    // wr_en is already false for the zero entry, so forwarding never leaks into it
    always_comb begin
        raw = mem[ra];
        if (FWD != 0 && wr_en && wa == ra)
            raw = wd;
        if (ZERO_REG != 0 && ra == '0)
            raw = '0;
    end
endmodule

module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_OUT  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [WIDTH-1:0]        wd,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD*WIDTH-1:0]  rd
);
    // A registered read must capture the word being written on the same edge,
    // so forwarding is always on in that mode.
    localparam int FWD = (BYPASS != 0 || REG_OUT != 0) ? 1 : 0;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [NREAD-1:0][WIDTH-1:0] raw;
    logic                        wr_en;

    assign wr_en = we && !reset && !(ZERO_REG != 0 && wa == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem <= '0;
        else if (wr_en)
            mem[wa] <= wd;
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        regfile_mp_rport #(
            .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
            .ZERO_REG(ZERO_REG), .FWD(FWD)
        ) u_rport (
            .mem  (mem),
            .wr_en(wr_en),
            .wa   (wa),
            .wd   (wd),
            .ra   (ra[i*ADDR_W +: ADDR_W]),
            .raw  (raw[i])
        );
    end

    if (REG_OUT != 0) begin : g_reg
        logic [NREAD-1:0][WIDTH-1:0] rd_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                rd_q <= '0;
            else
                rd_q <= raw;
        end
        assign rd = rd_q;
    end else begin : g_comb
        assign rd = raw;
    end
endmodule
